round_robin: RTL and testbench
==============================

Name: round_robin

Overview:
- Registered N-way round-robin arbiter, default 4 requesters.
- Samples a request vector every clock and issues a one-hot grant on the next cycle.
- Rotates priority so each active requester is served in turn.
- Sits between shared-resource clients and the resource; grants last exactly one cycle per arbitration.

Parameters:
- N, 4, number of requesters (>=2); width of REQ and GNT.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rstn  input  1  synchronous, active-high reset. Despite the port name, rstn=1 resets on a rising clk edge.
- REQ  input  N  request vector; bit i high = requester i wants the resource this cycle.
- GNT  output  N  registered grant vector; one-hot or all-zero.

Behaviour:
- State:
  - gnt_q[N-1:0] drives GNT directly.
  - ptr[$clog2(N)-1:0] is the highest-priority index for the next arbitration.
- Reset (rstn=1 at a rising edge):
  - gnt_q <= 0, ptr <= 0.
  - Reset has priority over everything, including mid-grant; the cycle after reset GNT=0 regardless of REQ.
- Each rising edge with rstn=0:
  - Search REQ starting at index ptr, ascending with wrap-around modulo N: ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
  - Let w be the first index with REQ[w]=1.
  - If a winner exists: gnt_q <= one-hot(w); ptr <= (w+1) mod N.
  - If REQ==0: gnt_q <= 0; ptr unchanged.
- Latency: GNT reflects REQ sampled at the previous rising edge (1-cycle registered latency). No combinational path from REQ to GNT.
- A grant lasts one cycle; there is no hold/lock. A requester that keeps REQ high is re-arbitrated every cycle.
- Single requester held high: it is granted every cycle, since ptr wraps back to it.
- All requesters high: grant rotates 0→1→2→...→N-1→0, one step per cycle.
- Fairness: a continuously asserted request is granted within N cycles.
- Invariant: GNT is one-hot or zero; never more than one bit set.
- Invariant: a GNT bit is set only if the corresponding REQ bit was high at the sampling edge.
- Wrap: w=N-1 gives ptr=0.
- No X-propagation allowed out of reset; GNT is defined from the first post-reset edge.

Decomposition:
- No shared package needed. A localparam PTR_W = $clog2(N) inside the module suffices; if a package is used, it holds only PTR_W / default N.
- One natural sub-module: rr_pick, purely combinational.
  - Inputs: REQ, ptr.
  - Outputs: valid, winner index, one-hot winner.
  - Implemented by rotating REQ right by ptr, fixed-priority LSB-first pick, then rotating back.
- The top level holds only the gnt_q/ptr registers and the reset logic.

Test Plan:
- Reset: rstn=1 for 2 edges with REQ=4'b1111 → GNT=4'b0000. After release, first grant is 4'b0001 (ptr=0).
- Idle and single request:
  - REQ=0 for several cycles → GNT=0 and ptr stays 0.
  - Then REQ=4'b0001 for 2 cycles → GNT=4'b0001 on both cycles after 1-cycle latency.
- Walking single request: REQ=0010, 0100, 1000, 2 cycles each → GNT follows one cycle late (0010, 0100, 1000). Each held request is re-granted both cycles.
- Full contention: REQ=4'b1111 for 10 cycles, starting after last grant to bit 3 → GNT sequence 0001, 0010, 0100, 1000, 0001, ... Each bit granted exactly every 4th cycle.
- Sparse pattern with wrap: REQ=4'b1010 after ptr=0 → GNT alternates 0010, 1000, 0010, 1000. REQ then goes to 0 → GNT=0 the next cycle, and ptr is retained so the next 4'b1010 resumes at the correct bit.
- Reset mid-operation: assert rstn during 4'b1111 rotation at GNT=0100 → next cycle GNT=0. After release, the grant restarts at 0001. Check one-hot/zero and GNT⊆previous-REQ assertions every cycle throughout.

Source files
------------

// File: rtl/round_robin_pkg.sv
// round_robin_pkg
//   Shared constants for the round-robin arbiter slice.
//   N_DEFAULT : default number of requesters.
//   ptr_width : width of the rotating-priority pointer for a given N.
package round_robin_pkg;

    localparam int N_DEFAULT = 4;

    function automatic int ptr_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/round_robin_if.sv
// round_robin_if
//   Request/grant bundle between clients and the arbiter.
//   REQ : request vector, bit i = client i wants the resource.
//   GNT : registered one-hot (or zero) grant vector.
//   master : client side (drives REQ, observes GNT).
//   slave  : arbiter side (observes REQ, drives GNT).
interface round_robin_if #(
    parameter int N = 4
);

    logic [N-1:0] REQ;
    logic [N-1:0] GNT;

    modport master (
        output REQ,
        input  GNT
    );

    modport slave (
        input  REQ,
        output GNT
    );

endinterface

// File: rtl/round_robin_rr_pick.sv
// round_robin_rr_pick
//   Combinational round-robin winner selection.
//   req    : request vector.
//   ptr    : index that holds highest priority this arbitration.
//   valid  : at least one request is present.
//   winner : index of the first requester at or after ptr (with wrap).
//   onehot : one-hot form of winner, zero when nothing requests.
module round_robin_rr_pick
    import round_robin_pkg::*;
#(
    parameter  int N     = N_DEFAULT,
    localparam int PTR_W = ptr_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic             valid,
    output logic [PTR_W-1:0] winner,
    output logic [N-1:0]     onehot
);

    logic [2*N-1:0]   req_dbl;
    logic [N-1:0]     req_rot;
    logic [PTR_W-1:0] first;
    int unsigned      sum;

    always_comb begin
        // Rotating right by ptr puts requester ptr at bit 0, so a plain
        // LSB-first pick on the rotated vector is the round-robin choice.
        req_dbl = {req, req};
        req_rot = req_dbl[ptr +: N];

        valid = 1'b0;
        first = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                valid = 1'b1;
                first = PTR_W'(i);
            end
        end

        // Rotate the pick back into absolute index space (mod N, which
        // need not be a power of two).
        sum = int'(unsigned'(first)) + int'(unsigned'(ptr));
        if (sum >= N) begin
            sum = sum - N;
        end
        winner = PTR_W'(sum);

        onehot = '0;
        if (valid) begin
            onehot[winner] = 1'b1;
        end
    end

endmodule

// File: rtl/round_robin.sv
// round_robin
//   Registered N-way round-robin arbiter. REQ is sampled on every rising
//   edge and a one-hot grant appears on GNT the following cycle; priority
//   rotates to just past the last winner.
//   clk  : system clock.
//   rstn : synchronous reset, active HIGH despite the name.
//   bus  : slave side of round_robin_if (REQ in, GNT out).
module round_robin
    import round_robin_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input logic        clk,
    input logic        rstn,
    round_robin_if.slave bus
);

    localparam int PTR_W = ptr_width(N);

    logic [N-1:0]     gnt_q;
    logic [PTR_W-1:0] ptr;

    logic             pick_valid;
    logic [PTR_W-1:0] pick_winner;
    logic [N-1:0]     pick_onehot;

    round_robin_rr_pick #(
        .N (N)
    ) u_pick (
        .req    (bus.REQ),
        .ptr    (ptr),
        .valid  (pick_valid),
        .winner (pick_winner),
        .onehot (pick_onehot)
    );

    always_ff @(posedge clk) begin
        if (rstn) begin
            gnt_q <= '0;
            ptr   <= '0;
        end else begin
            // An idle cycle keeps ptr so priority resumes where it left off.
            gnt_q <= pick_onehot;
            if (pick_valid) begin
                ptr <= (pick_winner == PTR_W'(N - 1)) ? '0 : pick_winner + 1'b1;
            end
        end
    end

    assign bus.GNT = gnt_q;

endmodule

// File: tb/tb_round_robin.sv
// tb_round_robin
//   Directed bench for the 4-way round_robin arbiter. Each step drives
//   rstn/REQ, waits one rising edge and compares GNT with a hand-computed
//   value, plus one-hot/zero and grant-implies-request checks.
module tb_round_robin;

    localparam int N = 4;

    logic clk;
    logic rstn;
    int   total;
    int   passed;

    round_robin_if #(.N(N)) bus ();

    round_robin #(
        .N (N)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic r, input logic [N-1:0] req,
                        input logic [N-1:0] exp, input string tag);
        logic [N-1:0] g;
        rstn    = r;
        bus.REQ = req;
        @(posedge clk);
        #1;
        g = bus.GNT;
        total++;
        assert (g === exp) passed++;
        else $error("FAIL %s: GNT=%b expected %b", tag, g, exp);
        total++;
        assert ($onehot0(g) === 1'b1) passed++;
        else $error("FAIL %s_onehot: GNT=%b expected one-hot or zero", tag, g);
        total++;
        assert ((g & ~req) === '0) passed++;
        else $error("FAIL %s_subset: GNT=%b REQ=%b expected GNT within REQ", tag, g, req);
    endtask

    task automatic check_ptr(input logic [1:0] exp, input string tag);
        logic [1:0] p;
        p = dut.ptr;
        total++;
        assert (p === exp) passed++;
        else $error("FAIL %s: ptr=%0d expected %0d", tag, p, exp);
    endtask

    initial begin
        total   = 0;
        passed  = 0;
        rstn    = 1'b1;
        bus.REQ = '0;

        // Reset held for two edges with all requests high.
        step(1'b1, 4'b1111, 4'b0000, "rst0");
        step(1'b1, 4'b1111, 4'b0000, "rst1");
        check_ptr(2'd0, "rst_ptr");

        // Idle after release.
        step(1'b0, 4'b0000, 4'b0000, "idle0");
        step(1'b0, 4'b0000, 4'b0000, "idle1");
        step(1'b0, 4'b0000, 4'b0000, "idle2");
        check_ptr(2'd0, "idle_ptr");

        // Single requester held: granted every cycle.
        step(1'b0, 4'b0001, 4'b0001, "single0a");
        step(1'b0, 4'b0001, 4'b0001, "single0b");

        // Walking single request.
        step(1'b0, 4'b0010, 4'b0010, "walk1a");
        step(1'b0, 4'b0010, 4'b0010, "walk1b");
        step(1'b0, 4'b0100, 4'b0100, "walk2a");
        step(1'b0, 4'b0100, 4'b0100, "walk2b");
        step(1'b0, 4'b1000, 4'b1000, "walk3a");
        step(1'b0, 4'b1000, 4'b1000, "walk3b");
        check_ptr(2'd0, "wrap_ptr");

        // Full contention from ptr=0: strict rotation, 12 cycles.
        step(1'b0, 4'b1111, 4'b0001, "all0");
        step(1'b0, 4'b1111, 4'b0010, "all1");
        step(1'b0, 4'b1111, 4'b0100, "all2");
        step(1'b0, 4'b1111, 4'b1000, "all3");
        step(1'b0, 4'b1111, 4'b0001, "all4");
        step(1'b0, 4'b1111, 4'b0010, "all5");
        step(1'b0, 4'b1111, 4'b0100, "all6");
        step(1'b0, 4'b1111, 4'b1000, "all7");
        step(1'b0, 4'b1111, 4'b0001, "all8");
        step(1'b0, 4'b1111, 4'b0010, "all9");
        step(1'b0, 4'b1111, 4'b0100, "all10");
        step(1'b0, 4'b1111, 4'b1000, "all11");
        check_ptr(2'd0, "all_ptr");

        // Sparse pattern alternating with wrap, then idle retains ptr.
        step(1'b0, 4'b1010, 4'b0010, "sparse0");
        step(1'b0, 4'b1010, 4'b1000, "sparse1");
        step(1'b0, 4'b1010, 4'b0010, "sparse2");
        step(1'b0, 4'b0000, 4'b0000, "sparse_idle");
        check_ptr(2'd2, "sparse_ptr");
        step(1'b0, 4'b1010, 4'b1000, "resume0");
        step(1'b0, 4'b1010, 4'b0010, "resume1");

        // Reset in the middle of a rotation.
        step(1'b0, 4'b1111, 4'b0100, "mid_rot");
        step(1'b1, 4'b1111, 4'b0000, "mid_rst");
        check_ptr(2'd0, "mid_ptr");
        step(1'b0, 4'b1111, 4'b0001, "post0");
        step(1'b0, 4'b1111, 4'b0010, "post1");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
